// File: rtl/lumini_intersectie_pkg.sv
// -----------------------------------------------------------------------------
// lumini_pkg
// Shared definitions for the intersection lamp driver, the phase sequencer and
// the stimulus block: phase codes, lamp encodings and the lamp-driver FSM
// state encoding.
// -----------------------------------------------------------------------------
package lumini_pkg;

    // Phase codes coming from the sequencer
    localparam logic [2:0] COD_SUD     = 3'b000;
    localparam logic [2:0] COD_EST     = 3'b001;
    localparam logic [2:0] COD_VEST    = 3'b010;
    localparam logic [2:0] COD_NORD    = 3'b011;
    localparam logic [2:0] COD_PIETONI = 3'b100;
    localparam logic [2:0] COD_SERVICE = 3'b111;

    // Vehicle lamp encodings {R,Y,G}
    localparam logic [2:0] ROSU_L   = 3'b100;
    localparam logic [2:0] GALBEN_L = 3'b010;
    localparam logic [2:0] VERDE_L  = 3'b001;

    // Pedestrian lamp encodings {R,G}
    localparam logic [1:0] PIETON_ROSU  = 2'b10;
    localparam logic [1:0] PIETON_VERDE = 2'b01;
    localparam logic [1:0] PIETON_STINS = 2'b00;

    typedef enum logic [2:0] {
        S_INCARCA = 3'd0,
        S_VERDE   = 3'd1,
        S_GALBEN  = 3'd2,
        S_ROSU    = 3'd3,
        S_GATA    = 3'd4,
        S_SERVICE = 3'd5
    } stare_t;

    // The undefined codes 101/110 are folded into service mode (fail-safe).
    function automatic logic is_service(input logic [2:0] cod);
        return (cod == COD_SERVICE) || (cod == 3'b101) || (cod == 3'b110);
    endfunction

endpackage

// File: rtl/lumini_intersectie_numarator_faza.sv
// -----------------------------------------------------------------------------
// numarator_faza
// Phase tick counter. Counts enable pulses (clk_div) since the last clear and
// flags the pulse that completes i_limit ticks.
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active low
//   i_clr    synchronous clear (state entry); wins over i_en
//   i_en     tick enable (clk_div)
//   i_limit  number of ticks in the current phase
//   o_done   high on the enable pulse that completes i_limit ticks
// -----------------------------------------------------------------------------
module numarator_faza #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;

    assign w_last = i_limit - ONE;
    assign o_done = i_en && (r_cnt == w_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/lumini_intersectie.sv
// -----------------------------------------------------------------------------
// lumini_intersectie
// Lamp driver for the 4-way intersection. Takes the phase code from the
// sequencer, times green / yellow / all-red clearance on clk_div ticks, drives
// the vehicle and pedestrian lamps and pulses ready_S when a phase completes.
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active low
//   clk_div        1-clk phase tick
//   clk_div_int    1-clk blink tick
//   stare_semafor  phase code (SUD/EST/VEST/NORD/PIETONI/SERVICE)
//   sem_sud/est/vest/nord  {R,Y,G} vehicle lamps
//   pieton         {R,G} pedestrian lamp
//   ready_S        1-clk pulse, phase finished
//
// state     | meaning
// ----------+-----------------------------------------------------
// INCARCA   | latch phase code, pick VERDE or SERVICE
// VERDE     | selected direction green / pedestrian steady walk
// GALBEN    | selected direction yellow / pedestrian blinking walk
// ROSU      | all-red clearance
// GATA      | all red, ready_S asserted for this single cycle
// SERVICE   | all vehicle lamps blink yellow, pedestrian dark
// -----------------------------------------------------------------------------
module lumini_intersectie
    import lumini_pkg::*;
#(
    parameter int T_VERDE  = 10,
    parameter int T_GALBEN = 3,
    parameter int T_ROSU   = 2,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_div,
    input  logic       clk_div_int,
    input  logic [2:0] stare_semafor,
    output logic [2:0] sem_sud,
    output logic [2:0] sem_est,
    output logic [2:0] sem_vest,
    output logic [2:0] sem_nord,
    output logic [1:0] pieton,
    output logic       ready_S
);

    stare_t     r_stare;
    logic [2:0] r_lat;
    logic       r_blink;
    logic [2:0] r_sem_sud, r_sem_est, r_sem_vest, r_sem_nord;
    logic [1:0] r_pieton;
    logic       r_ready;

    stare_t           w_stare_nxt;
    logic [2:0]       w_lat_nxt;
    logic             w_blink_nxt;
    logic             w_clr;
    logic             w_done;
    logic [CNT_W-1:0] w_limit;
    logic [2:0]       w_sud_nxt, w_est_nxt, w_vest_nxt, w_nord_nxt;
    logic [1:0]       w_pieton_nxt;
    logic             w_ready_nxt;
    logic             w_dir_on;
    logic [2:0]       w_dir_lamp;

    numarator_faza #(.CNT_W(CNT_W)) u_numarator (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (clk_div),
        .i_limit (w_limit),
        .o_done  (w_done)
    );

    always_comb begin
        case (r_stare)
            S_VERDE:  w_limit = CNT_W'(T_VERDE);
            S_GALBEN: w_limit = CNT_W'(T_GALBEN);
            S_ROSU:   w_limit = CNT_W'(T_ROSU);
            default:  w_limit = '0;
        endcase
    end

    always_comb begin
        w_stare_nxt = r_stare;
        w_lat_nxt   = r_lat;
        case (r_stare)
            S_INCARCA: begin
                w_lat_nxt   = stare_semafor;
                w_stare_nxt = is_service(stare_semafor) ? S_SERVICE : S_VERDE;
            end
            S_VERDE:   if (w_done) w_stare_nxt = S_GALBEN;
            S_GALBEN:  if (w_done) w_stare_nxt = S_ROSU;
            S_ROSU:    if (w_done) w_stare_nxt = S_GATA;
            S_GATA:    w_stare_nxt = S_INCARCA;
            S_SERVICE: if (!is_service(stare_semafor)) w_stare_nxt = S_ROSU;
            default:   w_stare_nxt = S_INCARCA;
        endcase
        // A live 111 overrides everything, including a phase tick landing on
        // the same cycle.
        if ((stare_semafor == COD_SERVICE) && (r_stare != S_SERVICE)) begin
            w_stare_nxt = S_SERVICE;
        end
    end

    assign w_clr = (w_stare_nxt != r_stare);

    // Entry clear wins over a coincident blink tick so blinking always starts dark.
    always_comb begin
        if (w_clr && ((w_stare_nxt == S_GALBEN) || (w_stare_nxt == S_SERVICE))) begin
            w_blink_nxt = 1'b0;
        end else if (clk_div_int) begin
            w_blink_nxt = ~r_blink;
        end else begin
            w_blink_nxt = r_blink;
        end
    end

    // Lamp values are decoded from the next state so the registered outputs
    // change on the same edge that the FSM enters a state.
    always_comb begin
        w_sud_nxt    = ROSU_L;
        w_est_nxt    = ROSU_L;
        w_vest_nxt   = ROSU_L;
        w_nord_nxt   = ROSU_L;
        w_pieton_nxt = PIETON_ROSU;
        w_ready_nxt  = 1'b0;
        w_dir_on     = 1'b0;
        w_dir_lamp   = ROSU_L;
        case (w_stare_nxt)
            S_VERDE: begin
                if (w_lat_nxt == COD_PIETONI) begin
                    w_pieton_nxt = PIETON_VERDE;
                end else begin
                    w_dir_on   = 1'b1;
                    w_dir_lamp = VERDE_L;
                end
            end
            S_GALBEN: begin
                if (w_lat_nxt == COD_PIETONI) begin
                    w_pieton_nxt = {1'b0, w_blink_nxt};
                end else begin
                    w_dir_on   = 1'b1;
                    w_dir_lamp = GALBEN_L;
                end
            end
            S_GATA: w_ready_nxt = 1'b1;
            S_SERVICE: begin
                w_sud_nxt    = {1'b0, w_blink_nxt, 1'b0};
                w_est_nxt    = {1'b0, w_blink_nxt, 1'b0};
                w_vest_nxt   = {1'b0, w_blink_nxt, 1'b0};
                w_nord_nxt   = {1'b0, w_blink_nxt, 1'b0};
                w_pieton_nxt = PIETON_STINS;
            end
            default: ;
        endcase
        if (w_dir_on) begin
            case (w_lat_nxt[1:0])
                2'd0:    w_sud_nxt  = w_dir_lamp;
                2'd1:    w_est_nxt  = w_dir_lamp;
                2'd2:    w_vest_nxt = w_dir_lamp;
                default: w_nord_nxt = w_dir_lamp;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stare    <= S_INCARCA;
            r_lat      <= COD_SUD;
            r_blink    <= 1'b0;
            r_sem_sud  <= ROSU_L;
            r_sem_est  <= ROSU_L;
            r_sem_vest <= ROSU_L;
            r_sem_nord <= ROSU_L;
            r_pieton   <= PIETON_ROSU;
            r_ready    <= 1'b0;
        end else begin
            r_stare    <= w_stare_nxt;
            r_lat      <= w_lat_nxt;
            r_blink    <= w_blink_nxt;
            r_sem_sud  <= w_sud_nxt;
            r_sem_est  <= w_est_nxt;
            r_sem_vest <= w_vest_nxt;
            r_sem_nord <= w_nord_nxt;
            r_pieton   <= w_pieton_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign sem_sud  = r_sem_sud;
    assign sem_est  = r_sem_est;
    assign sem_vest = r_sem_vest;
    assign sem_nord = r_sem_nord;
    assign pieton   = r_pieton;
    assign ready_S  = r_ready;

endmodule

// File: tb/tb_lumini_intersectie.sv
module tb_lumini_intersectie;

    localparam int T_VERDE  = 10;
    localparam int T_GALBEN = 3;
    localparam int T_ROSU   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_div = 1'b0;
    logic       clk_div_int = 1'b0;
    logic [2:0] stare_semafor = 3'b000;
    logic [2:0] sem_sud, sem_est, sem_vest, sem_nord;
    logic [1:0] pieton;
    logic       ready_S;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd = 0;

    always #5 clk = ~clk;

    lumini_intersectie #(
        .T_VERDE(T_VERDE), .T_GALBEN(T_GALBEN), .T_ROSU(T_ROSU), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .clk_div_int(clk_div_int),
        .stare_semafor(stare_semafor),
        .sem_sud(sem_sud), .sem_est(sem_est), .sem_vest(sem_vest), .sem_nord(sem_nord),
        .pieton(pieton), .ready_S(ready_S)
    );

    // Behavioural model: a phase is a list of segments, each with a number of
    // ticks still to run.
    typedef enum int {M_LOAD, M_GREEN, M_YELLOW, M_CLEAR, M_READY, M_SERV} mseg_t;
    mseg_t      m_seg = M_LOAD;
    int         m_left = 0;
    logic [2:0] m_code = 3'b000;
    logic       m_blink = 1'b0;
    mseg_t      m_prev;
    logic       m_svc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_seg = M_LOAD; m_left = 0; m_code = 3'b000; m_blink = 1'b0;
        end else begin
            m_prev = m_seg;
            m_svc  = (stare_semafor == 3'd5) || (stare_semafor == 3'd6) || (stare_semafor == 3'd7);
            if (stare_semafor == 3'd7 && m_seg != M_SERV) begin
                m_seg = M_SERV;
            end else begin
                case (m_seg)
                    M_LOAD: begin
                        m_code = stare_semafor;
                        if (m_svc) m_seg = M_SERV;
                        else begin m_seg = M_GREEN; m_left = T_VERDE; end
                    end
                    M_GREEN: if (clk_div) begin
                        m_left--;
                        if (m_left == 0) begin m_seg = M_YELLOW; m_left = T_GALBEN; end
                    end
                    M_YELLOW: if (clk_div) begin
                        m_left--;
                        if (m_left == 0) begin m_seg = M_CLEAR; m_left = T_ROSU; end
                    end
                    M_CLEAR: if (clk_div) begin
                        m_left--;
                        if (m_left == 0) m_seg = M_READY;
                    end
                    M_READY: m_seg = M_LOAD;
                    M_SERV: if (!m_svc) begin m_seg = M_CLEAR; m_left = T_ROSU; end
                    default: m_seg = M_LOAD;
                endcase
            end
            if (m_seg != m_prev && (m_seg == M_YELLOW || m_seg == M_SERV)) m_blink = 1'b0;
            else if (clk_div_int) m_blink = ~m_blink;
        end
    end

    // {sud, est, vest, nord, pieton, ready}
    function automatic logic [14:0] expect_out(mseg_t s, logic [2:0] code, logic b);
        logic [2:0] v [4];
        logic [1:0] p;
        logic       r;
        for (int k = 0; k < 4; k++) v[k] = 3'b100;
        p = 2'b10;
        r = 1'b0;
        case (s)
            M_GREEN:  if (code == 3'd4) p = 2'b01; else v[code[1:0]] = 3'b001;
            M_YELLOW: if (code == 3'd4) p = b ? 2'b01 : 2'b00; else v[code[1:0]] = 3'b010;
            M_READY:  r = 1'b1;
            M_SERV: begin
                for (int k = 0; k < 4; k++) v[k] = {1'b0, b, 1'b0};
                p = 2'b00;
            end
            default: ;
        endcase
        return {v[0], v[1], v[2], v[3], p, r};
    endfunction

    logic [14:0] exp_v, got_v;
    int          nonred;

    always @(negedge clk) begin
        exp_v = expect_out(m_seg, m_code, m_blink);
        got_v = {sem_sud, sem_est, sem_vest, sem_nord, pieton, ready_S};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%b exp=%b seg=%0d", $time, got_v, exp_v, int'(m_seg));
        end
        nonred = 0;
        if (sem_sud  != 3'b100) nonred++;
        if (sem_est  != 3'b100) nonred++;
        if (sem_vest != 3'b100) nonred++;
        if (sem_nord != 3'b100) nonred++;
        checks++;
        if ((m_seg != M_SERV && nonred > 1) || (pieton == 2'b01 && nonred != 0)) begin
            errors++;
            $display("FAIL safety t=%0t nonred=%0d pieton=%b", $time, nonred, pieton);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge, away from both the
    // compare process and the DUT's sampling edge.
    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        if (rnd) begin
            clk_div     = ($urandom_range(2) == 0);
            clk_div_int = ($urandom_range(3) == 0);
        end else begin
            clk_div     = (cyc % 4 == 0);
            clk_div_int = (cyc % 2 == 0);
        end
    endtask

    function automatic logic [2:0] pick_code();
        int r;
        r = $urandom_range(9);
        if (r < 7) return 3'(r % 5);
        if (r == 7) return 3'd7;
        if (r == 8) return 3'd5;
        return 3'd6;
    endfunction

    initial begin
        int gt, yt, rt, rdy, rc, gc, cnt, bad;
        bit seen_y, done1, found;

        #1 rst = 1'b0;
        step(); step();
        chk("reset_sud", sem_sud, 3'b100);
        chk("reset_nord", sem_nord, 3'b100);
        chk("reset_pieton", pieton, 2'b10);
        chk("reset_ready", ready_S, 0);

        // SUD phase, one tick every 4 clocks
        stare_semafor = 3'd0;
        rst = 1'b1;
        gt = 0; yt = 0; rt = 0; rdy = 0; rc = -1; gc = -1; seen_y = 0; done1 = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ready_S) rdy++;
            if (!done1) begin
                if (sem_sud == 3'b001 && clk_div) gt++;
                if (sem_sud == 3'b010) begin
                    seen_y = 1;
                    if (clk_div) yt++;
                end else if (seen_y && sem_sud == 3'b100 && !ready_S && clk_div) rt++;
                if (ready_S) begin done1 = 1; rc = i; end
            end else if (gc < 0 && sem_sud == 3'b001) gc = i;
        end
        chk("sud_green_ticks", gt, 10);
        chk("sud_yellow_ticks", yt, 3);
        chk("sud_red_ticks", rt, 2);
        chk("sud_ready_cycles", rdy, 1);
        chk("sud_regreen_lat", gc - rc, 2);

        // EST, switched to NORD mid-green
        stare_semafor = 3'd1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin step(); found = (sem_est == 3'b001); end
        chk("wait_est_green", found, 1);
        repeat (10) step();
        stare_semafor = 3'd3;
        found = 0; bad = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (sem_nord != 3'b100) bad++;
            found = ready_S;
        end
        chk("est_ready_seen", found, 1);
        chk("nord_lit_during_est", bad, 0);
        step(); step();
        chk("nord_after_gata", sem_nord, 3'b001);

        // PIETONI
        stare_semafor = 3'd4;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin step(); found = (pieton == 2'b01); end
        chk("wait_walk", found, 1);
        cnt = clk_div ? 1 : 0; bad = 0;
        for (int i = 0; i < 200 && !ready_S; i++) begin
            step();
            if (sem_sud != 3'b100 || sem_est != 3'b100 || sem_vest != 3'b100 || sem_nord != 3'b100) bad++;
            if (pieton == 2'b00 && cnt < 100) cnt = cnt + 1000;
            if (pieton == 2'b01 && clk_div && cnt < 1000) cnt++;
        end
        chk("walk_steady_ticks", cnt - 1000, 10);
        chk("walk_vehicles_red", bad, 0);

        // SERVICE during VEST yellow
        stare_semafor = 3'd2;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin step(); found = (sem_vest == 3'b010); end
        chk("wait_vest_yellow", found, 1);
        stare_semafor = 3'd7;
        step();
        chk("svc_entry_lamps", {sem_sud, sem_est, sem_vest, sem_nord}, 12'h000);
        chk("svc_entry_pieton", pieton, 2'b00);
        rdy = 0; bad = 0;
        repeat (20) begin
            step();
            if (ready_S) rdy++;
            if (sem_sud[2] | sem_sud[0] | sem_vest[2] | sem_vest[0]) bad++;
        end
        chk("svc_no_ready", rdy, 0);
        chk("svc_only_yellow", bad, 0);
        stare_semafor = 3'd0;
        found = 0; rt = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = ready_S;
            if (!ready_S && clk_div && {sem_sud, sem_est, sem_vest, sem_nord} == 12'h924) rt++;
        end
        chk("svc_exit_ready", found, 1);
        chk("svc_exit_red_ticks", rt, 2);
        step(); step();
        chk("svc_exit_sud_green", sem_sud, 3'b001);

        // Undefined code 101 behaves as SERVICE
        stare_semafor = 3'd5;
        repeat (100) step();
        chk("c101_pieton", pieton, 2'b00);
        chk("c101_sud_not_red", sem_sud[2], 0);
        chk("c101_nord_not_green", sem_nord[0], 0);

        // Async reset mid-green
        stare_semafor = 3'd1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin step(); found = (sem_est == 3'b001); end
        chk("wait_est_green2", found, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_est", sem_est, 3'b100);
        chk("async_rst_ready", ready_S, 0);
        chk("async_rst_pieton", pieton, 2'b10);
        step(); step();
        rst = 1'b1;
        step();
        chk("post_rst_green", sem_est, 3'b001);

        // Randomized traffic
        rnd = 1;
        for (int i = 0; i < 15000; i++) begin
            step();
            if ($urandom_range(39) == 0) stare_semafor = pick_code();
            if ($urandom_range(2999) == 0) begin
                rst = 1'b0;
                step(); step();
                rst = 1'b1;
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
